// File: rtl/VX_ecc_pkg.sv
// Shared ECC definitions: scrubber state encoding and Hamming width helpers.
package VX_ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR_REQ,
    NEXT
  } scrub_state_e;

  function automatic int calculate_hamming_bits(input int data_bits);
    for (int m = 1; m < 31; m++) begin
      if ((1 << m) >= data_bits + m + 1) return m;
    end
    return 31;
  endfunction

  function automatic int encoded_bits(input int data_bits);
    return data_bits + calculate_hamming_bits(data_bits) + 1;
  endfunction

endpackage

// File: rtl/VX_hamming_dec.sv
// SECDED decoder matching VX_hamming_enc; corrects singles, flags doubles.
module VX_hamming_dec
  import VX_ecc_pkg::*;
#(
  parameter int DATA_BITS = 15,
  localparam int HB = calculate_hamming_bits(DATA_BITS),
  localparam int CB = DATA_BITS + HB,
  localparam int EB = CB + 1
) (
  input  logic [EB-1:0]        data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic [HB-1:0]        syndrome,
  output logic                 corrected,
  output logic                 invalid
);

  logic [CB-1:0] code;
  logic          odd;
  logic          in_range;

  always_comb begin
    syndrome = '0;
    for (int pos = 1; pos <= CB; pos++) begin
      if (data_in[pos-1]) syndrome = syndrome ^ HB'(pos);
    end
  end

  assign odd       = ^data_in;
  assign in_range  = int'(syndrome) <= CB;
  assign corrected = odd && (syndrome != '0) && in_range;
  assign invalid   = (syndrome != '0) && !corrected;

  always_comb begin
    int j;
    code = data_in[CB-1:0];
    if (corrected) begin
      code[int'(syndrome)-1] = ~code[int'(syndrome)-1];
    end
    data_out = '0;
    j = 0;
    for (int pos = 1; pos <= CB; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        data_out[j] = code[pos-1];
        j++;
      end
    end
  end

endmodule

// File: rtl/VX_hamming_enc.sv
// SECDED encoder: Hamming positions 1..N in bits [N-1:0], overall parity on top.
module VX_hamming_enc
  import VX_ecc_pkg::*;
#(
  parameter int DATA_BITS = 15,
  localparam int HB = calculate_hamming_bits(DATA_BITS),
  localparam int CB = DATA_BITS + HB,
  localparam int EB = CB + 1
) (
  input  logic [DATA_BITS-1:0] data_in,
  output logic [EB-1:0]        data_out
);

  logic [CB-1:0] code;

  always_comb begin
    int j;
    code = '0;
    j = 0;
    for (int pos = 1; pos <= CB; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        code[pos-1] = data_in[j];
        j++;
      end
    end
    // check bits sit at power-of-two positions and never cover each other
    for (int p = 0; p < HB; p++) begin
      for (int pos = 1; pos <= CB; pos++) begin
        if (((pos >> p) & 1) == 1 && pos != (1 << p)) begin
          code[(1<<p)-1] = code[(1<<p)-1] ^ code[pos-1];
        end
      end
    end
  end

  assign data_out = {^code, code};

endmodule

// File: rtl/vx_ecc_scrubber.sv
// Background ECC scrubber: walks the array, repairs single errors,
// counts corrected/uncorrectable events and reports each one.
module vx_ecc_scrubber
  import VX_ecc_pkg::*;
#(
  parameter int DATA_BITS      = 15,
  parameter int HAMMING_BITS   = calculate_hamming_bits(DATA_BITS),
  parameter int ENCODED_BITS   = DATA_BITS + HAMMING_BITS + 1,
  parameter int NUM_LINES      = 64,
  parameter int ADDR_BITS      = $clog2(NUM_LINES),
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_BITS       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [ADDR_BITS-1:0]    mem_req_addr,
  output logic [ENCODED_BITS-1:0] mem_req_data,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [ENCODED_BITS-1:0] mem_rsp_data,
  input  logic                    core_wr_valid,
  input  logic [ADDR_BITS-1:0]    core_wr_addr,
  output logic                    err_valid,
  output logic                    err_uncorrectable,
  output logic [ADDR_BITS-1:0]    err_addr,
  output logic [CNT_BITS-1:0]     corr_count,
  output logic [CNT_BITS-1:0]     uncorr_count,
  output logic                    busy
);

  localparam int IW = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [IW-1:0] ILAST = IW'(SCRUB_INTERVAL - 1);
  localparam logic [CNT_BITS-1:0] CMAX = '1;

  scrub_state_e state, state_n;

  logic [IW-1:0]           icnt;
  logic [ADDR_BITS-1:0]    addr;
  logic [ENCODED_BITS-1:0] word;
  logic                    hazard;
  logic                    hit;
  logic                    hazard_now;
  logic                    parity_only;
  logic                    fix;
  logic [DATA_BITS-1:0]    dec_data;
  logic [HAMMING_BITS-1:0] syndrome;
  logic                    dec_corr;
  logic                    dec_inv;
  logic [ENCODED_BITS-1:0] enc_word;

  VX_hamming_dec #(.DATA_BITS(DATA_BITS)) dec (
    .data_in   (word),
    .data_out  (dec_data),
    .syndrome  (syndrome),
    .corrected (dec_corr),
    .invalid   (dec_inv)
  );

  VX_hamming_enc #(.DATA_BITS(DATA_BITS)) enc (
    .data_in  (dec_data),
    .data_out (enc_word)
  );

  assign hit         = core_wr_valid && (core_wr_addr == addr);
  assign hazard_now  = hazard || hit;
  // a flipped overall-parity bit leaves the syndrome clean
  assign parity_only = (^word) && (syndrome == '0);
  assign fix         = dec_corr || parity_only;

  assign busy         = state != IDLE;
  assign mem_req_rw   = state == WR_REQ;
  assign mem_req_addr = addr;
  assign mem_req_data = (state == WR_REQ) ? enc_word : '0;

  always_comb begin
    state_n       = state;
    mem_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && icnt == ILAST) state_n = RD_REQ;
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rsp_valid) state_n = CHECK;
      end
      CHECK: begin
        state_n = (fix && !hazard_now) ? WR_REQ : NEXT;
      end
      WR_REQ: begin
        mem_req_valid = !hazard;
        if (hazard || mem_req_ready) state_n = NEXT;
      end
      NEXT: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      icnt              <= '0;
      addr              <= '0;
      word              <= '0;
      hazard            <= 1'b0;
      err_valid         <= 1'b0;
      err_uncorrectable <= 1'b0;
      err_addr          <= '0;
      corr_count        <= '0;
      uncorr_count      <= '0;
    end else begin
      state     <= state_n;
      err_valid <= 1'b0;
      if (state == IDLE) begin
        icnt <= (!enable || icnt == ILAST) ? '0 : icnt + 1'b1;
      end
      if (state == RD_REQ && mem_req_ready) begin
        hazard <= hit;
      end else if (hit) begin
        hazard <= 1'b1;
      end
      if (state == RD_WAIT && mem_rsp_valid) begin
        word <= mem_rsp_data;
      end
      if (state == CHECK && (fix || dec_inv)) begin
        err_valid         <= 1'b1;
        err_uncorrectable <= dec_inv;
        err_addr          <= addr;
        if (fix && corr_count != CMAX) begin
          corr_count <= corr_count + 1'b1;
        end
        if (dec_inv && uncorr_count != CMAX) begin
          uncorr_count <= uncorr_count + 1'b1;
        end
      end
      if (state == NEXT && enable) begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_ecc_scrubber.sv
// Directed bench for vx_ecc_scrubber: table of corrupted lines plus
// hand sequences for hazards, mid-write reset and counter saturation.
module tb_vx_ecc_scrubber;

  localparam int EB = 21;
  localparam int NL = 4;
  localparam int AB = 2;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [EB-1:0] mem_req_data;
  logic          mem_req_ready = 1'b1;
  logic          mem_rsp_valid;
  logic [EB-1:0] mem_rsp_data;
  logic          core_wr_valid = 1'b0;
  logic [AB-1:0] core_wr_addr = '0;
  logic          err_valid;
  logic          err_uncorrectable;
  logic [AB-1:0] err_addr;
  logic [CB-1:0] corr_count;
  logic [CB-1:0] uncorr_count;
  logic          busy;

  always #5 clk = ~clk;

  vx_ecc_scrubber #(
    .DATA_BITS(15), .NUM_LINES(NL),
    .SCRUB_INTERVAL(8), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .core_wr_valid(core_wr_valid),
    .core_wr_addr(core_wr_addr), .err_valid(err_valid),
    .err_uncorrectable(err_uncorrectable), .err_addr(err_addr),
    .corr_count(corr_count), .uncorr_count(uncorr_count),
    .busy(busy)
  );

  typedef struct {
    int            addr;
    logic [EB-1:0] word;
    logic [EB-1:0] fixed;
    bit            err;
    bit            unc;
    bit            wr;
  } vec_t;

  logic [EB-1:0] mem [NL];
  int            n_rd, n_wr, n_err, rd_hits, wr_hits, tgt;
  int            rd_log[$];
  logic [EB-1:0] last_wdata;
  logic          last_unc;
  logic [AB-1:0] last_eaddr;
  bit            recorrupt = 1'b0;
  int            passed = 0;
  int            total = 0;
  int            exp_corr = 0;
  int            exp_unc = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // array model: 1-cycle read latency, applies handshaked writes
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      logic          hs;
      logic          rw;
      logic [AB-1:0] a;
      logic [EB-1:0] d;
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      rw = mem_req_rw;
      a  = mem_req_addr;
      d  = mem_req_data;
      if (err_valid) begin
        n_err++;
        last_unc   = err_uncorrectable;
        last_eaddr = err_addr;
      end
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (hs && reset && !rw) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem[a];
        n_rd++;
        rd_log.push_back(int'(a));
        if (int'(a) == tgt) rd_hits++;
      end
      if (hs && reset && rw) begin
        mem[a] = recorrupt ? (d ^ 21'h40) : d;
        n_wr++;
        last_wdata = d;
        if (int'(a) == tgt) wr_hits++;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 300);
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_rd_req(input int a);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      seen = mem_req_valid && !mem_req_rw && int'(mem_req_addr) == a;
    end
    check("rd_req_timeout", {63'd0, seen}, 64'd1);
  endtask

  task automatic wait_rd_hits(input int n);
    int k = 0;
    while (rd_hits < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rd_hit_timeout", 64'(rd_hits >= n), 64'd1);
  endtask

  task automatic start_line(input int a, input logic [EB-1:0] w);
    mem[a]  = w;
    tgt     = a;
    rd_hits = 0;
    wr_hits = 0;
    n_err   = 0;
  endtask

  vec_t vt[5];

  initial begin
    int cyc;
    int k;
    vt[0] = '{2, 21'h100047, 21'h100007, 1'b1, 1'b0, 1'b1};
    vt[1] = '{1, 21'h188200, 21'h188008, 1'b1, 1'b1, 1'b0};
    vt[2] = '{0, 21'h000007, 21'h100007, 1'b1, 1'b0, 1'b1};
    vt[3] = '{3, 21'h188008, 21'h188008, 1'b0, 1'b0, 1'b0};
    vt[4] = '{2, 21'h189008, 21'h188008, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < NL; i++) mem[i] = '0;
    tgt = -1;

    #3 reset = 1'b0;
    #1;
    check("reset_outputs",
      64'({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
           err_valid, err_uncorrectable, err_addr,
           corr_count, uncorr_count, busy}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    n_rd = 0;
    n_wr = 0;
    n_err = 0;
    rd_log.delete();
    enable = 1'b1;
    cyc = 0;
    while (!mem_req_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("first_read_latency", 64'(cyc), 64'd8);

    k = 0;
    while (n_rd < 5 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("clean_read_count", 64'(n_rd >= 5), 64'd1);
    for (int i = 0; i < 5 && i < rd_log.size(); i++) begin
      check("clean_read_addr", 64'(rd_log[i]), 64'(i % NL));
    end
    check("clean_writes", 64'(n_wr), 64'd0);
    check("clean_errors", 64'(n_err), 64'd0);
    check("clean_counts", 64'({corr_count, uncorr_count}), 64'd0);

    foreach (vt[i]) begin
      wait_idle();
      start_line(vt[i].addr, vt[i].word);
      wait_rd_hits(1);
      wait_idle();
      if (vt[i].err && !vt[i].unc) exp_corr++;
      if (vt[i].unc) exp_unc++;
      check("vec_err", 64'(n_err), 64'(vt[i].err));
      if (vt[i].err) begin
        check("vec_err_unc", 64'(last_unc), 64'(vt[i].unc));
        check("vec_err_addr", 64'(last_eaddr), 64'(vt[i].addr));
      end
      check("vec_write", 64'(wr_hits), 64'(vt[i].wr));
      if (vt[i].wr) check("vec_wdata", 64'(last_wdata), 64'(vt[i].fixed));
      check("vec_mem", 64'(mem[vt[i].addr]),
            64'(vt[i].wr ? vt[i].fixed : vt[i].word));
      check("vec_corr", 64'(corr_count), 64'(exp_corr));
      check("vec_unc", 64'(uncorr_count), 64'(exp_unc));
      mem[vt[i].addr] = vt[i].fixed;
    end

    // double error survives two passes untouched
    wait_idle();
    start_line(1, 21'h188200);
    wait_rd_hits(2);
    wait_idle();
    exp_unc += 2;
    check("dbl_unc", 64'(uncorr_count), 64'(exp_unc));
    check("dbl_nowrite", 64'(wr_hits), 64'd0);
    check("dbl_mem", 64'(mem[1]), 64'h188200);
    mem[1] = 21'h188008;

    // core write to the line while the read is outstanding
    wait_idle();
    start_line(3, 21'h188048);
    wait_rd_req(3);
    @(posedge clk);
    #1;
    core_wr_valid = 1'b1;
    core_wr_addr  = 2'd3;
    @(posedge clk);
    #1 core_wr_valid = 1'b0;
    wait_idle();
    exp_corr++;
    check("hz1_corr", 64'(corr_count), 64'(exp_corr));
    check("hz1_nowrite", 64'(wr_hits), 64'd0);
    check("hz1_err_addr", 64'(last_eaddr), 64'd3);
    mem[3] = 21'h188008;

    // core write while the write-back is stalled: request withdrawn
    wait_idle();
    start_line(3, 21'h188048);
    wait_rd_req(3);
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(mem_req_valid && mem_req_rw) && k < 20);
    check("hz2_wr_pending", 64'(mem_req_valid && mem_req_rw), 64'd1);
    check("hz2_wr_data", 64'(mem_req_data), 64'h188008);
    @(posedge clk);
    #1;
    core_wr_valid = 1'b1;
    core_wr_addr  = 2'd3;
    @(posedge clk);
    #1 core_wr_valid = 1'b0;
    check("hz2_withdrawn", 64'({mem_req_valid, busy}), 64'b01);
    mem_req_ready = 1'b1;
    wait_idle();
    exp_corr++;
    check("hz2_corr", 64'(corr_count), 64'(exp_corr));
    check("hz2_nowrite", 64'(wr_hits), 64'd0);
    mem[3] = 21'h188008;

    // asynchronous reset while a write-back is pending
    wait_idle();
    start_line(2, 21'h100047);
    wait_rd_req(2);
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(mem_req_valid && mem_req_rw) && k < 20);
    #1 reset = 1'b0;
    #1;
    check("wr_reset_outputs",
      64'({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
           err_valid, err_uncorrectable, err_addr,
           corr_count, uncorr_count, busy}), 64'd0);
    mem_req_ready = 1'b1;
    mem[2] = 21'h100007;
    @(posedge clk);
    #1 reset = 1'b1;
    rd_log.delete();
    n_rd = 0;
    k = 0;
    while (n_rd < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("restart_read", 64'(n_rd >= 1), 64'd1);
    if (rd_log.size() > 0) check("restart_addr", 64'(rd_log[0]), 64'd0);

    // every write-back is re-corrupted, so each scrub counts again
    wait_idle();
    recorrupt = 1'b1;
    for (int i = 0; i < NL; i++) mem[i] = mem[i] ^ 21'h40;
    n_err = 0;
    k = 0;
    while (n_err < 18 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    wait_idle();
    check("sat_events", 64'(n_err >= 18), 64'd1);
    check("sat_corr", 64'(corr_count), 64'hF);
    check("sat_unc", 64'(uncorr_count), 64'd0);

    // disabled scrubber stays quiet
    enable = 1'b0;
    wait_idle();
    n_rd = 0;
    repeat (40) @(posedge clk);
    #1;
    check("disabled_reads", 64'(n_rd), 64'd0);
    check("disabled_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vx_ecc_scrubber.md
Name: vx_ecc_scrubber

Overview:
- Background ECC scrubber for ECC-protected cache data arrays; sits directly downstream of the Hamming decoder.
- Periodically walks every line of the array: reads the encoded word, decodes it with VX_hamming_dec, re-encodes correctable words with VX_hamming_enc and writes them back.
- Keeps saturating error counters and emits a per-event error report.
- Shares the array port with the core through an external arbiter that drives mem_req_ready.

Parameters:
- DATA_BITS, 15: payload bits per line.
- HAMMING_BITS, calculate_hamming_bits(DATA_BITS): check bits; 5 for the default.
- ENCODED_BITS, DATA_BITS+HAMMING_BITS+1: stored word width, including the overall parity bit; 21 for the default.
- NUM_LINES, 64: lines in the array; power of two, at least 2.
- ADDR_BITS, $clog2(NUM_LINES): line address width.
- SCRUB_INTERVAL, 1024: idle cycles between successive line scrubs; at least 1.
- CNT_BITS, 16: width of the error counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  scrubbing allowed.
- mem_req_valid  out  1  array request.
- mem_req_rw  out  1  0=read, 1=write.
- mem_req_addr  out  ADDR_BITS  line address.
- mem_req_data  out  ENCODED_BITS  write data.
- mem_req_ready  in  1  arbiter grant.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  ENCODED_BITS  encoded read data.
- core_wr_valid  in  1  core write snoop.
- core_wr_addr  in  ADDR_BITS  core write address.
- err_valid  out  1  one-cycle error report.
- err_uncorrectable  out  1  qualifies err_valid: 1=double error.
- err_addr  out  ADDR_BITS  line address of the report.
- corr_count  out  CNT_BITS  corrected errors, saturating.
- uncorr_count  out  CNT_BITS  uncorrectable errors, saturating.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset low, asynchronous): every output register is 0, state=IDLE, scrub address=0, interval counter=0.
- IDLE:
  - Interval counter increments while enable=1 and clears while enable=0.
  - When the counter reaches SCRUB_INTERVAL-1: clear the counter and go to RD_REQ.
- RD_REQ:
  - Drive mem_req_valid=1, rw=0, addr=scrub address.
  - Request fields hold stable until mem_req_ready=1 in the same cycle; that handshake moves to RD_WAIT.
  - Clear the hazard flag on that handshake.
- RD_WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid, register mem_rsp_data and go to CHECK.
  - No timeout; response latency is arbitrary (minimum 1 cycle).
- Hazard flag: set in any cycle from the read handshake up to the write handshake in which core_wr_valid=1 and core_wr_addr equals the scrub address.
- CHECK (one cycle; decoder output comes from the registered word):
  - Parity-only error = overall parity ^word is 1 and syndrome is 0. The decoder does not flag it, but the scrubber treats it as corrected.
  - corrected or parity-only:
    - err_valid=1, err_uncorrectable=0, err_addr=scrub address.
    - corr_count increments (saturating at all-ones).
    - Next state is WR_REQ, unless the hazard flag is set, in which case the write-back is skipped and the state goes to NEXT. The error is still counted.
  - invalid (double error):
    - err_valid=1, err_uncorrectable=1.
    - uncorr_count increments (saturating).
    - No write-back; go to NEXT.
  - Clean word: go to NEXT with no report.
- WR_REQ:
  - mem_req_valid=1, rw=1, data=VX_hamming_enc(decoded data).
  - If the hazard flag becomes set while waiting for ready: drop the request (valid falls) and go to NEXT.
  - Otherwise the handshake moves to NEXT.
- NEXT:
  - Scrub address increments, wrapping NUM_LINES-1 to 0.
  - If enable=1: go to IDLE.
  - If enable=0: go to IDLE and hold the address.
- enable falling mid-scrub: the current line completes (read, check, write-back); no new line starts.
- err_valid is a single-cycle pulse; err_addr and err_uncorrectable are meaningful only while it is high and otherwise hold their last value.
- Simultaneous core write and scrubber read handshake in the same cycle to the same address: the hazard flag is set.
- Counters are cleared only by reset.

Decomposition:
- Shared package (VX_ecc_pkg):
  - Scrubber state encoding: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
  - calculate_hamming_bits function.
  - Encoded-width helper.
- Instantiates the existing VX_hamming_dec (check) and VX_hamming_enc (write-back).
- No new sub-module; the state machine, interval counter and saturating counters live in one module.

Test Plan:
- Clean array, NUM_LINES=4, SCRUB_INTERVAL=8, ready always 1, 1-cycle rsp:
  - 4 reads to addresses 0,1,2,3 then 0 again; first read issued 8 cycles after enable rises.
  - No writes, no err_valid, counters stay 0.
- Flip encoded bit 6 of line 2:
  - Write to addr 2 with the original encoded word.
  - err_valid pulse with err_addr=2, uncorrectable=0; corr_count=1.
- Flip bits 3 and 9 of line 1:
  - err_valid with uncorrectable=1, uncorr_count=1.
  - No write to addr 1; the line stays corrupted on the next pass.
- Flip only the top parity bit of line 0: write-back restores the word; corr_count=1.
- Single error on line 3 with core_wr_valid to addr 3 during RD_WAIT:
  - corr_count=1, no scrubber write.
  - Repeat with the core write while WR_REQ is stalled by ready=0: the request is withdrawn.
- Reset asserted while in WR_REQ:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release the scrub address restarts at 0.
  - Preload corr_count near saturation (force 0xFFFE) and inject 3 errors: the counter sticks at 0xFFFF.
